regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the CPU datapath: integer GPR storage with configurable width, depth and number of read ports.
- Adds asynchronous reset, an optional hardwired-zero register 0, write modes (full, upper-immediate, low-half merge), optional write-to-read bypass and a per-register pending scoreboard.
- Sits between decode (read and issue side) and writeback (write side).
- Decode uses the busy flags to stall on read-after-write hazards from multicycle units.

Parameters:
- DW, 32, data width in bits; must be even.
- DEPTH, 32, number of registers.
- AW, 5, address width; DEPTH must be at most 2^AW.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, when 1, register 0 always reads 0, ignores writes and never goes pending.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- raddr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rdata  out  NUM_RD*DW  read data; port k occupies bits [k*DW +: DW]; combinational.
- rbusy  out  NUM_RD  port k's source register is pending and not being resolved this cycle.
- wren  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- wmode  in  2  write mode: 0 full, 1 upper, 2 low-merge, 3 reserved (write ignored).
- iss_en  in  1  mark iss_addr pending (a long-latency producer was issued).
- iss_addr  in  AW  register to mark pending.
- any_busy  out  1  OR of all pending bits; registered.

Behaviour:
- Reset (async, rst=1):
  - All DEPTH registers are cleared to 0.
  - All pending bits are cleared; any_busy=0.
  - Reset asserted mid-operation discards any write or issue in that cycle.
  - With rst held, rdata=0 and rbusy=0 for every port.
- Write value (wv), by mode:
  - Mode 0: wv = wdata.
  - Mode 1: wv = {wdata[DW/2-1:0], DW/2 zeros} (LUI semantics).
  - Mode 2: wv = {reg[waddr][DW-1:DW/2], wdata[DW/2-1:0]}.
  - Mode 3: no array update, but the pending clear below still happens.
- Write timing:
  - wv is committed at the clock edge when wren=1.
  - waddr >= DEPTH is ignored.
  - With ZERO_REG=1, waddr=0 is ignored.
- Read:
  - rdata[k] = reg[raddr[k]] combinationally.
  - raddr >= DEPTH reads 0.
  - raddr=0 with ZERO_REG=1 reads 0.
- Bypass (BYPASS=1):
  - If wren=1, the mode is 0–2, waddr is valid (nonzero when ZERO_REG=1) and waddr==raddr[k], then rdata[k]=wv in the same cycle.
  - With BYPASS=0, the new value is visible from the cycle after the edge.
- Scoreboard (one pending bit per register):
  - Edge with wren=1 and a valid waddr: pend[waddr] is cleared, in any mode.
  - Edge with iss_en=1 and a valid iss_addr: pend[iss_addr] is set.
  - iss_en and wren to the same address in the same cycle: the set wins and pend stays 1 (new producer outstanding).
  - Different addresses in the same cycle: both updates apply.
  - Issuing to a register that is already pending keeps it at 1; there is no counting.
- rbusy[k] = pend[raddr[k]] AND NOT (BYPASS AND a valid write to raddr[k] this cycle).
  - With BYPASS=0, rbusy follows pend only.
  - Always 0 for register 0 when ZERO_REG=1, and for out-of-range addresses.
- any_busy is registered: it reflects the pending set after the most recent edge.
- Multiple read ports may use the same address; each produces identical results.

Optional Feature:
- Macro: REGFILE_MP_DEBUG_EN.
- When defined, two extra ports are present:
  - dbg_addr  in  AW.
  - dbg_data  out  DW; returns the raw array content at dbg_addr.
- dbg_data never uses bypass, returns 0 for out-of-range addresses, and is 0 during reset.
- When not defined, neither port exists and no debug logic is generated.

Test Plan:
- Reset then read every register -> rdata=0 and rbusy=0 on all ports; then assert rst mid-write with wren=1, waddr=5, wdata=0xDEADBEEF -> reg5 reads 0 after rst falls.
- Mode 1 write with waddr=3, wdata=0x00001234, followed by mode 2 write with waddr=3, wdata=0xFFFF5678 -> reg3=0x12345678.
- ZERO_REG=1, write wdata=0xFFFFFFFF to waddr=0 and also issue iss_en to iss_addr=0 -> rdata=0, rbusy=0, any_busy=0.
- BYPASS=1, raddr0=7, same-cycle write of 0xA5A5A5A5 to waddr=7 -> rdata0=0xA5A5A5A5 in that cycle; with BYPASS=0 the old value is read, and the new value the next cycle.
- Issue iss_addr=9; next cycle rbusy=1 for raddr=9 and any_busy=1; writeback to 9 with BYPASS=1 -> rbusy=0 in the write cycle and pend cleared after the edge; simultaneous iss_en and wren to 9 -> pend stays 1.
- NUM_RD=3, all three ports reading address 4 holding 0x0BADF00D -> all three rdata slices equal 0x0BADF00D; with REGFILE_MP_DEBUG_EN, dbg_addr=4 gives 0x0BADF00D.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp : multi-port general purpose register file with pending scoreboard
//
// Sits between decode (read/issue side) and writeback (write side). Decode reads
// operands combinationally and uses the busy flags to stall on read-after-write
// hazards against long-latency producers.
//
// Parameters
//   DW       data width in bits (even)
//   DEPTH    number of registers (DEPTH <= 2**AW)
//   AW       address width
//   NUM_RD   number of read ports
//   ZERO_REG 1: register 0 reads 0, ignores writes, never goes pending
//   BYPASS   1: a same-cycle write is forwarded to matching read ports
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   raddr     read addresses, port k at [k*AW +: AW]
//   rdata     read data, port k at [k*DW +: DW] (combinational)
//   rbusy     port k source register pending and not resolved this cycle
//   wren      write enable
//   waddr     write address
//   wdata     write data
//   wmode     0 full, 1 upper (LUI), 2 low-half merge, 3 no data update
//   iss_en    mark iss_addr pending
//   iss_addr  register to mark pending
//   any_busy  OR of all pending bits (registered)
//
// Optional build macro REGFILE_MP_DEBUG_EN adds:
//   dbg_addr  raw array peek address
//   dbg_data  raw array content at dbg_addr (no bypass, 0 out of range/reset)
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] raddr,
    output logic [NUM_RD*DW-1:0] rdata,
    output logic [NUM_RD-1:0]    rbusy,
    input  logic                 wren,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [1:0]           wmode,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 any_busy
`ifdef REGFILE_MP_DEBUG_EN
    ,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DW-1:0]        dbg_data
`endif
);

    localparam int HW = DW / 2;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             any_busy_q;

    logic [DW-1:0]    wr_old;
    logic [DW-1:0]    wv;
    logic             wr_hit;      // write to a usable register, any mode
    logic             wr_data_en;  // write that actually changes the array
    logic             iss_hit;

    // Address exists in the array.
    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Address names a writable / trackable register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_hit     = wren && addr_ok(waddr);
    assign wr_data_en = wr_hit && (wmode != 2'd3);
    assign iss_hit    = iss_en && addr_ok(iss_addr);

    // Write value formation; mode 2 needs the current register content.
    always_comb begin
        wr_old = in_range(waddr) ? mem_q[waddr] : '0;
        case (wmode)
            2'd1:    wv = {wdata[HW-1:0], {HW{1'b0}}};
            2'd2:    wv = {wr_old[DW-1:HW], wdata[HW-1:0]};
            default: wv = wdata;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_data_en) begin
            mem_d[waddr] = wv;
        end
    end

    // Clear before set: a new producer issued in the same cycle as the
    // writeback of the old one leaves the register pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_hit) begin
            pend_d[waddr] = 1'b0;
        end
        if (iss_hit) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            any_busy_q <= |pend_d;
        end
    end

    assign any_busy = any_busy_q;

    // Read ports. Outputs are forced to 0 while reset is held so decode never
    // sees stale operands or busy flags during the reset window.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok;
        logic          byp;
        logic          resolve;

        assign ra      = raddr[k*AW +: AW];
        assign ok      = addr_ok(ra);
        assign byp     = (BYPASS != 0) && wr_data_en && (waddr == ra);
        assign resolve = (BYPASS != 0) && wr_hit && (waddr == ra);

        assign rdata[k*DW +: DW] = (rst || !ok) ? '0 :
                                   byp          ? wv : mem_q[ra];
        assign rbusy[k]          = !rst && ok && pend_q[ra] && !resolve;
    end

`ifdef REGFILE_MP_DEBUG_EN
    assign dbg_data = (rst || !in_range(dbg_addr)) ? '0 : mem_q[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wren = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  wmode = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [4:0]  ra0 = '0;
    logic [4:0]  ra1 = '0;

    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic [1:0]  rbusy_a;
    logic        any_a;
    logic [14:0] raddr_b;
    logic [95:0] rdata_b;
    logic [2:0]  rbusy_b;
    logic        any_b;
`ifdef REGFILE_MP_DEBUG_EN
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_a;
    logic [31:0] dbg_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    assign raddr_a = {ra1, ra0};
    assign raddr_b = {ra0, ra0, ra0};

    always #5 clk = ~clk;

    // Default build: bypass on, two read ports.
    regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .wren(wren), .waddr(waddr), .wdata(wdata), .wmode(wmode),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_a)
`ifdef REGFILE_MP_DEBUG_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_a)
`endif
    );

    // No bypass, three read ports all reading ra0.
    regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NUM_RD(3), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .wren(wren), .waddr(waddr), .wdata(wdata), .wmode(wmode),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_b)
`ifdef REGFILE_MP_DEBUG_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_b)
`endif
    );

    typedef struct {
        logic        wren;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  wmode;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;   // bypass instance, port 0
        logic [31:0] e_rd1;   // bypass instance, port 1
        logic        e_b0;
        logic        e_b1;
        logic        e_any;
        logic [31:0] e_nb;    // no-bypass instance, every port (reads ra0)
        logic        e_nbb;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [1:0] wm, input logic ie, input logic [4:0] ia,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic b0, input logic b1, input logic an,
                                input logic [31:0] nb, input logic nbb);
        vec_t v;
        v.wren = we; v.waddr = wa; v.wdata = wd; v.wmode = wm;
        v.iss_en = ie; v.iss_addr = ia; v.ra0 = r0; v.ra1 = r1;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_b0 = b0; v.e_b1 = b1; v.e_any = an;
        v.e_nb = nb; v.e_nbb = nbb;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wren = 1'b0; waddr = '0; wdata = '0; wmode = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        //              we wa  wdata         wm ie ia  r0  r1  e_rd0         e_rd1         b0 b1 any e_nb          nbb
        vecs[0]  = mk(1, 3,  32'h00001234, 1, 0, 0,  3,  0,  32'h12340000, 32'h0,        0, 0, 0, 32'h0,        0);
        vecs[1]  = mk(1, 3,  32'hFFFF5678, 2, 0, 0,  3,  3,  32'h12345678, 32'h12345678, 0, 0, 0, 32'h12340000, 0);
        vecs[2]  = mk(0, 0,  32'h0,        0, 0, 0,  3,  0,  32'h12345678, 32'h0,        0, 0, 0, 32'h12345678, 0);
        vecs[3]  = mk(1, 0,  32'hFFFFFFFF, 0, 1, 0,  0,  0,  32'h0,        32'h0,        0, 0, 0, 32'h0,        0);
        vecs[4]  = mk(0, 0,  32'h0,        0, 0, 0,  0,  3,  32'h0,        32'h12345678, 0, 0, 0, 32'h0,        0);
        vecs[5]  = mk(1, 7,  32'hA5A5A5A5, 0, 0, 0,  7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        0);
        vecs[6]  = mk(0, 0,  32'h0,        0, 1, 9,  9,  7,  32'h0,        32'hA5A5A5A5, 0, 0, 0, 32'h0,        0);
        vecs[7]  = mk(0, 0,  32'h0,        0, 0, 0,  9,  9,  32'h0,        32'h0,        1, 1, 1, 32'h0,        1);
        vecs[8]  = mk(1, 9,  32'h11112222, 0, 0, 0,  9,  8,  32'h11112222, 32'h0,        0, 0, 1, 32'h0,        1);
        vecs[9]  = mk(0, 0,  32'h0,        0, 0, 0,  9,  7,  32'h11112222, 32'hA5A5A5A5, 0, 0, 0, 32'h11112222, 0);
        vecs[10] = mk(0, 0,  32'h0,        0, 1, 9,  9,  9,  32'h11112222, 32'h11112222, 0, 0, 0, 32'h11112222, 0);
        vecs[11] = mk(1, 9,  32'h33334444, 0, 1, 9,  9,  9,  32'h33334444, 32'h33334444, 0, 0, 1, 32'h11112222, 1);
        vecs[12] = mk(0, 0,  32'h0,        0, 0, 0,  9,  9,  32'h33334444, 32'h33334444, 1, 1, 1, 32'h33334444, 1);
        vecs[13] = mk(1, 9,  32'hFFFFFFFF, 3, 1, 10, 10, 8,  32'h0,        32'h0,        0, 0, 1, 32'h0,        0);
        vecs[14] = mk(0, 0,  32'h0,        0, 0, 0,  9,  10, 32'h33334444, 32'h0,        0, 1, 1, 32'h33334444, 0);
        vecs[15] = mk(1, 10, 32'h00000055, 0, 0, 0,  31, 10, 32'h0,        32'h00000055, 0, 0, 1, 32'h0,        0);
        vecs[16] = mk(1, 4,  32'h0BADF00D, 0, 0, 0,  4,  10, 32'h0BADF00D, 32'h00000055, 0, 0, 0, 32'h0,        0);
        vecs[17] = mk(0, 0,  32'h0,        0, 0, 0,  4,  4,  32'h0BADF00D, 32'h0BADF00D, 0, 0, 0, 32'h0BADF00D, 0);
        vecs[18] = mk(1, 31, 32'hFFFFABCD, 2, 0, 0,  31, 3,  32'h0000ABCD, 32'h12345678, 0, 0, 0, 32'h0,        0);
        vecs[19] = mk(0, 0,  32'h0,        0, 0, 0,  31, 31, 32'h0000ABCD, 32'h0000ABCD, 0, 0, 0, 32'h0000ABCD, 0);

        // Reset held: outputs forced low.
        @(negedge clk);
        ra0 = 5'd3; ra1 = 5'd31;
        #1;
        chk("rst_rdata0", 0, rdata_a[31:0], 32'h0);
        chk("rst_rdata1", 0, rdata_a[63:32], 32'h0);
        chk("rst_rbusy", 0, {30'h0, rbusy_a}, 32'h0);
        chk("rst_any", 0, {31'h0, any_a}, 32'h0);
        chk("rst_any_nb", 0, {31'h0, any_b}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a); ra1 = 5'(31 - a);
            #1;
            chk("clr_rd0", a, rdata_a[31:0], 32'h0);
            chk("clr_rd1", a, rdata_a[63:32], 32'h0);
            chk("clr_busy", a, {30'h0, rbusy_a}, 32'h0);
            chk("clr_nb", a, rdata_b[95:64], 32'h0);
        end

        // Reset asserted during a write cycle discards the write.
        @(negedge clk);
        wren = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wmode = 2'd0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        ra0 = 5'd5;
        #1;
        chk("rst_midwr_a", 0, rdata_a[31:0], 32'h0);
        chk("rst_midwr_b", 0, rdata_b[31:0], 32'h0);

        // Table-driven body.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wren = vecs[i].wren; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            wmode = vecs[i].wmode; iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
            ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            #1;
            chk("rdata0", i, rdata_a[31:0], vecs[i].e_rd0);
            chk("rdata1", i, rdata_a[63:32], vecs[i].e_rd1);
            chk("rbusy0", i, {31'h0, rbusy_a[0]}, {31'h0, vecs[i].e_b0});
            chk("rbusy1", i, {31'h0, rbusy_a[1]}, {31'h0, vecs[i].e_b1});
            chk("any_busy", i, {31'h0, any_a}, {31'h0, vecs[i].e_any});
            chk("nb_rdata0", i, rdata_b[31:0], vecs[i].e_nb);
            chk("nb_rdata1", i, rdata_b[63:32], vecs[i].e_nb);
            chk("nb_rdata2", i, rdata_b[95:64], vecs[i].e_nb);
            chk("nb_rbusy", i, {29'h0, rbusy_b}, vecs[i].e_nbb ? 32'h7 : 32'h0);
            chk("nb_any", i, {31'h0, any_b}, {31'h0, vecs[i].e_any});
        end

        @(negedge clk);
        idle_inputs();
`ifdef REGFILE_MP_DEBUG_EN
        dbg_addr = 5'd4;
        #1;
        chk("dbg_a", 4, dbg_a, 32'h0BADF00D);
        chk("dbg_b", 4, dbg_b, 32'h0BADF00D);
        dbg_addr = 5'd31;
        #1;
        chk("dbg_a", 31, dbg_a, 32'h0000ABCD);
`endif

        // Pending register, then reset mid-operation clears data and scoreboard.
        iss_en = 1'b1; iss_addr = 5'd12;
        @(negedge clk);
        idle_inputs();
        ra0 = 5'd12; ra1 = 5'd4;
        #1;
        chk("pend12_busy", 0, {31'h0, rbusy_a[0]}, 32'h1);
        chk("pend12_any", 0, {31'h0, any_a}, 32'h1);
        chk("reg4_pre", 0, rdata_a[63:32], 32'h0BADF00D);
        rst = 1'b1;
        #1;
        chk("rst_hold_rd", 0, rdata_a[63:32], 32'h0);
        chk("rst_hold_busy", 0, {30'h0, rbusy_a}, 32'h0);
        chk("rst_hold_any", 0, {31'h0, any_a}, 32'h0);
`ifdef REGFILE_MP_DEBUG_EN
        chk("rst_hold_dbg", 0, dbg_a, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rd", 0, rdata_a[63:32], 32'h0);
        chk("post_rst_busy", 0, {30'h0, rbusy_a}, 32'h0);
        chk("post_rst_any", 0, {31'h0, any_a}, 32'h0);
        chk("post_rst_nb", 0, {29'h0, rbusy_b}, 32'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
